dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the load/store requests the pipeline issues from its MEM stage. Accepts one request at a time over a valid/ready handshake and models a fixed multi-cycle access latency. Drives a stall back to the pipeline while an access is outstanding, then returns read data or a write acknowledge with an error flag. It is the memory-side counterpart of the processor's MemRead/MemWrite initiator.

Parameters:
DATA_W, 64, data word width in bits; multiple of 8.
DEPTH_LOG2, 8, log2 of memory depth in words (256 words).
LATENCY, 2, WAIT-state cycles per access; legal range 1..15.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  DATA_W  store data
req_strb  input  DATA_W/8  byte enables for stores; ignored for loads
rsp_valid  output  1  response valid, single-cycle pulse
rsp_rdata  output  DATA_W  load data; 0 for stores, errors and outside RESP
rsp_err  output  1  misaligned or out-of-range access, valid with rsp_valid
stall  output  1  pipeline hold request

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-low.
- While rst is low:
  - state = IDLE and counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, stall = 0, req_ready = 0.
  - Memory array contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1 and stall = 0.
  - On an edge with req_valid = 1, the request is accepted. Latch write, addr, wdata and strb, load counter = LATENCY-1 and go to WAIT.
  - With req_valid = 0, stay in IDLE.
- WAIT:
  - req_ready = 0 and stall = 1.
  - On each edge where counter != 0, decrement the counter.
  - On the edge where counter == 0, perform the access and go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle; there is no backpressure.
  - req_ready = 0 and stall = 0.
  - Unconditionally go to IDLE on the next edge.
- Latency: if the handshake occurs in cycle T, WAIT spans T+1..T+LATENCY and rsp_valid = 1 in cycle T+LATENCY+1. The earliest next accept is in cycle T+LATENCY+2.
- stall, req_ready and rsp_valid are decoded from registered state only. None of them combinationally depend on req_valid.
- Address decode:
  - Word index = req_addr[DEPTH_LOG2+2:3].
  - Misaligned when req_addr[2:0] != 0.
  - Out of range when req_addr >= 8·2^DEPTH_LOG2, i.e. any bit above DEPTH_LOG2+2 is set.
  - On either condition: rsp_err = 1, rsp_rdata = 0, and no memory write occurs.
- Store (no error):
  - Each byte i with strb[i] = 1 is replaced by wdata byte i; other bytes are unchanged.
  - strb = 0 is a legal no-op write and still responds with rsp_err = 0.
  - rsp_rdata = 0.
- Load (no error): rsp_rdata = memory word as it stood before the WAIT→RESP edge.
- Reset mid-operation: any pending access is discarded.
  - If rst falls during WAIT, no memory write occurs and no response is produced.
  - If rst falls during RESP, rsp_valid is cleared immediately.
- Inputs other than req_valid are sampled only on the accepting edge. Changes during WAIT or RESP are ignored.

Test Plan:
- Reset, then store addr 0x10, wdata 0x1122334455667788, strb 0xFF, then load addr 0x10 (LATENCY = 2) -> the store gets rsp_valid 3 cycles after its handshake with rsp_err = 0 and rdata = 0; the load returns 0x1122334455667788; stall is high exactly 2 cycles per access.
- Over that word, store 0xAAAAAAAAAAAAAAAA with strb 0x0F, then load addr 0x10 -> 0x11223344AAAAAAAA.
- Load addr 0x13, then store addr 0x800 with strb 0xFF -> both respond rsp_err = 1 and rsp_rdata = 0; a subsequent load of addr 0x800 & 0x7F8 = 0x000 shows unchanged content.
- Hold req_valid = 1 continuously with back-to-back loads to 0x0 and 0x8 -> req_ready is low during WAIT and RESP; the second handshake occurs exactly LATENCY+2 cycles after the first.
- Store 0xFF..FF to 0x20, and assert rst low for one cycle in the first WAIT cycle -> all outputs go to 0 immediately and no rsp_valid pulse appears; a later load of 0x20 returns the old contents.
- LATENCY = 1 build, load addr 0x8 -> rsp_valid is high in cycle T+2; stall is high for 1 cycle only.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the data-memory responder.
interface dmem_responder_if #(
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed WAIT latency, stall while busy,
// one-cycle response pulse with error flag for misaligned / out-of-range accesses.
module dmem_byte_lane (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module dmem_responder #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                       state;
  logic [3:0]                   cnt;
  logic                         wr_q;
  logic [31:0]                  addr_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [NUM_LANES-1:0]         strb_q;
  logic [DATA_W-1:0]            rdata_q;
  logic                         err_q;

  // Contents survive reset, so the array sits outside the reset domain.
  logic [DATA_W-1:0]            mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0]        idx;
  logic                         err;
  logic                         fire;
  logic [DATA_W-1:0]            cur;
  logic [NUM_LANES-1:0][7:0]    merged;

  assign idx  = addr_q[DEPTH_LOG2+2:3];
  assign err  = (addr_q[2:0] != 3'd0) | (|addr_q[31:DEPTH_LOG2+3]);
  assign fire = (state == WAIT) && (cnt == 4'd0);
  assign cur  = mem[idx];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_byte_lane u_lane (
      .en    (strb_q[l]),
      .old_b (cur[8*l +: 8]),
      .new_b (wdata_q[8*l +: 8]),
      .out_b (merged[l])
    );
  end

  always_ff @(posedge clk) begin
    if (fire && wr_q && !err) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          wr_q    <= bus.req_write;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          strb_q  <= bus.req_strb;
          cnt     <= 4'(LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          // Load data is the word as it stood before any same-edge store.
          rdata_q <= (!wr_q && !err) ? cur : '0;
          err_q   <= err;
          state   <= RESP;
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is gated by rst so it reads 0 while reset is held even though state is IDLE.
  assign bus.req_ready = (state == IDLE) & rst;
  assign bus.stall     = (state == WAIT);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Drives a LATENCY=2 and a LATENCY=1 responder with identical requests and checks
// both against a word-array reference model with cycle-exact response timing.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_strb  = '0;

  int tests = 0;
  int fails = 0;
  logic [63:0] model [256];

  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(64)) b2 ();
  dmem_responder_if #(.DATA_W(64)) b1 ();

  assign b2.req_valid = req_valid;  assign b1.req_valid = req_valid;
  assign b2.req_write = req_write;  assign b1.req_write = req_write;
  assign b2.req_addr  = req_addr;   assign b1.req_addr  = req_addr;
  assign b2.req_wdata = req_wdata;  assign b1.req_wdata = req_wdata;
  assign b2.req_strb  = req_strb;   assign b1.req_strb  = req_strb;

  dmem_responder #(.DATA_W(64), .DEPTH_LOG2(8), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.DATA_W(64), .DEPTH_LOG2(8), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // index 0 = LATENCY 2 instance, index 1 = LATENCY 1 instance
  logic [1:0]  o_stall, o_vld, o_rdy, o_err;
  logic [63:0] o_rd [2];
  assign o_stall = {b1.stall,     b2.stall};
  assign o_vld   = {b1.rsp_valid, b2.rsp_valid};
  assign o_rdy   = {b1.req_ready, b2.req_ready};
  assign o_err   = {b1.rsp_err,   b2.rsp_err};
  assign o_rd[0] = b2.rsp_rdata;
  assign o_rd[1] = b1.rsp_rdata;

  task automatic chk(input string tag, input int dut, input int k, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d k=%0d observed=%h expected=%h", tag, dut, k, obs, exp);
    end
  endtask

  task automatic scramble();
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_strb  = 8'($urandom);
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bit e;
    int i;
    int lat;
    logic [63:0] exp;
    e   = (a[2:0] != 3'd0) || (a >= 32'h800);
    i   = int'(a[10:3]);
    exp = (!w && !e) ? model[i] : 64'd0;
    if (w && !e)
      for (int b = 0; b < 8; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    for (int u = 0; u < 2; u++) chk("ready_idle", u, 0, 64'(o_rdy[u]), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      scramble();
      for (int u = 0; u < 2; u++) begin
        lat = (u == 0) ? 2 : 1;
        chk("stall", u, k, 64'(o_stall[u]), 64'(k <= lat));
        chk("rsp_valid", u, k, 64'(o_vld[u]), 64'(k == lat + 1));
        chk("req_ready", u, k, 64'(o_rdy[u]), 64'(k >= lat + 2));
        chk("rsp_err", u, k, 64'(o_err[u]), (k == lat + 1) ? 64'(e) : 64'd0);
        chk("rsp_rdata", u, k, o_rd[u], (k == lat + 1) ? exp : 64'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int r;
    #1 rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_stall", u, 0, 64'(o_stall[u]), 64'd0);
      chk("rst_vld",   u, 0, 64'(o_vld[u]),   64'd0);
      chk("rst_rdy",   u, 0, 64'(o_rdy[u]),   64'd0);
      chk("rst_err",   u, 0, 64'(o_err[u]),   64'd0);
      chk("rst_rdata", u, 0, o_rd[u],         64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Give every word a known value so later loads have a defined expectation.
    for (int i = 0; i < 256; i++) xact(1'b1, 32'(i * 8), {$urandom, $urandom}, 8'hFF);

    xact(1'b1, 32'h10, 64'h1122334455667788, 8'hFF);
    xact(1'b0, 32'h10, 64'd0, 8'h00);
    xact(1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    xact(1'b0, 32'h10, 64'd0, 8'h00);
    xact(1'b0, 32'h13, 64'd0, 8'h00);
    xact(1'b1, 32'h800, 64'hDEADBEEFDEADBEEF, 8'hFF);
    xact(1'b0, 32'h000, 64'd0, 8'h00);
    xact(1'b1, 32'h18, 64'h0123456789ABCDEF, 8'h00);
    xact(1'b0, 32'h18, 64'd0, 8'h00);
    xact(1'b0, 32'h7F8, 64'd0, 8'h00);

    // Held valid: second accept must land LATENCY+2 cycles after the first.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    chk("b2b_ready0", 0, 0, 64'(o_rdy[0]), 64'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = 32'h8;
      chk("b2b_ready", 0, k, 64'(o_rdy[0]), 64'(k == 4));
      chk("b2b_vld", 0, k, 64'(o_vld[0]), 64'(k == 3 || k == 7));
      if (k == 3) chk("b2b_rd0", 0, k, o_rd[0], model[0]);
      if (k == 7) begin
        chk("b2b_rd1", 0, k, o_rd[0], model[1]);
        req_valid = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Reset during the first WAIT cycle discards the store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = '1; req_strb = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("mid_stall", u, 1, 64'(o_stall[u]), 64'd0);
      chk("mid_vld",   u, 1, 64'(o_vld[u]),   64'd0);
      chk("mid_rdy",   u, 1, 64'(o_rdy[u]),   64'd0);
      chk("mid_err",   u, 1, 64'(o_err[u]),   64'd0);
      chk("mid_rdata", u, 1, o_rd[u],         64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) chk("no_rsp", u, k, 64'(o_vld[u]), 64'd0);
    end
    xact(1'b0, 32'h20, 64'd0, 8'h00);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = {21'd0, 8'($urandom), 3'd0};
      if (r == 0) a = a | 32'($urandom_range(1, 7));
      else if (r == 1) a = $urandom | 32'h800;
      xact(1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
